// File: rtl/intr_timer_ctrl.sv
// Memory-mapped 64-bit machine timer plus synchronized, edge-triggered external
// interrupt, presenting a registered two-bit interrupt vector to the CSR file.
module intr_timer_ctrl #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_2000,
   parameter int unsigned PRESCALE  = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rd_en,
   input  logic        wr_en,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [2:0]  mem_mode,
   output logic [31:0] rdata,
   output logic        hit,
   input  logic        ext_irq,
   input  logic        epc_taken,
   output logic [1:0]  interrupt
);

   localparam int unsigned PS_W      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [2:0]  MODE_WORD = 3'b010;

   localparam logic [2:0] OFF_MTIME_LO = 3'd0;
   localparam logic [2:0] OFF_MTIME_HI = 3'd1;
   localparam logic [2:0] OFF_CMP_LO   = 3'd2;
   localparam logic [2:0] OFF_CMP_HI   = 3'd3;
   localparam logic [2:0] OFF_CTRL     = 3'd4;
   localparam logic [2:0] OFF_STATUS   = 3'd5;

   logic [PS_W-1:0] ps_q, ps_d;
   logic [63:0]     mtime_q, mtime_d;
   logic [63:0]     mtimecmp_q, mtimecmp_d;
   logic [1:0]      ctrl_q, ctrl_d;
   logic            ext_pend_q, ext_pend_d;
   logic            ext_s1_q, ext_s2_q, ext_s3_q;
   logic [1:0]      irq_q, irq_d;

   logic       word_acc;
   logic       wr_sel;
   logic [2:0] off;
   logic       tick;
   logic       timer_pend;
   logic       ext_edge;
   logic       ext_clr;

   assign hit        = (addr[31:5] == BASE_ADDR[31:5]);
   assign word_acc   = (mem_mode == MODE_WORD) && (addr[1:0] == 2'b00);
   assign wr_sel     = wr_en && hit && word_acc;
   assign off        = addr[4:2];
   assign tick       = (ps_q == PS_W'(PRESCALE - 1));
   assign timer_pend = (mtime_q >= mtimecmp_q);
   assign ext_edge   = ext_s2_q & ~ext_s3_q;
   assign ext_clr    = (epc_taken && irq_q[1]) ||
                       (wr_sel && (off == OFF_STATUS) && wdata[1]);
   assign interrupt  = irq_q;

   // Next-state: a bus write to one mtime half overrides that cycle's increment
   // and leaves the other half at its pre-increment value.
   always_comb begin
      ps_d       = tick ? '0 : ps_q + PS_W'(1);
      mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
      mtimecmp_d = mtimecmp_q;
      ctrl_d     = ctrl_q;
      ext_pend_d = ext_pend_q;
      irq_d      = {ext_pend_q & ctrl_q[1], timer_pend & ctrl_q[0]};

      if (wr_sel) begin
         case (off)
            OFF_MTIME_LO: mtime_d    = {mtime_q[63:32], wdata};
            OFF_MTIME_HI: mtime_d    = {wdata, mtime_q[31:0]};
            OFF_CMP_LO:   mtimecmp_d = {mtimecmp_q[63:32], wdata};
            OFF_CMP_HI:   mtimecmp_d = {wdata, mtimecmp_q[31:0]};
            OFF_CTRL:     ctrl_d     = wdata[1:0];
            default:      ;
         endcase
      end

      // A new edge outranks any clear arriving in the same cycle.
      if (ext_edge) begin
         ext_pend_d = 1'b1;
      end else if (ext_clr) begin
         ext_pend_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ps_q       <= '0;
         mtime_q    <= '0;
         mtimecmp_q <= '1;
         ctrl_q     <= '0;
         ext_pend_q <= 1'b0;
         ext_s1_q   <= 1'b0;
         ext_s2_q   <= 1'b0;
         ext_s3_q   <= 1'b0;
         irq_q      <= '0;
      end else begin
         ps_q       <= ps_d;
         mtime_q    <= mtime_d;
         mtimecmp_q <= mtimecmp_d;
         ctrl_q     <= ctrl_d;
         ext_pend_q <= ext_pend_d;
         ext_s1_q   <= ext_irq;
         ext_s2_q   <= ext_s1_q;
         ext_s3_q   <= ext_s2_q;
         irq_q      <= irq_d;
      end
   end

   // Load data is combinational so the core can latch it in the request cycle.
   always_comb begin
      rdata = '0;
      if (rd_en && hit && word_acc) begin
         case (off)
            OFF_MTIME_LO: rdata = mtime_q[31:0];
            OFF_MTIME_HI: rdata = mtime_q[63:32];
            OFF_CMP_LO:   rdata = mtimecmp_q[31:0];
            OFF_CMP_HI:   rdata = mtimecmp_q[63:32];
            OFF_CTRL:     rdata = {30'd0, ctrl_q};
            OFF_STATUS:   rdata = {30'd0, ext_pend_q, timer_pend};
            default:      rdata = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_intr_timer_ctrl.sv
// Bench for intr_timer_ctrl: directed scenarios then random bus/interrupt traffic,
// all checked against a cycle-level behavioural model of the register window.
module tb_intr_timer_ctrl;

   localparam logic [31:0] BASE = 32'h0000_2000;
   localparam int unsigned PS   = 1;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rd_en = 1'b0, wr_en = 1'b0, ext_irq = 1'b0, epc_taken = 1'b0;
   logic [31:0] addr = '0, wdata = '0;
   logic [2:0]  mem_mode = 3'b010;
   logic [31:0] rdata;
   logic        hit;
   logic [1:0]  interrupt;

   intr_timer_ctrl #(.BASE_ADDR(BASE), .PRESCALE(PS)) dut (
      .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .addr(addr),
      .wdata(wdata), .mem_mode(mem_mode), .rdata(rdata), .hit(hit),
      .ext_irq(ext_irq), .epc_taken(epc_taken), .interrupt(interrupt)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Behavioural model state
   logic [63:0] m_mtime, m_cmp;
   logic [1:0]  m_ctrl, m_irq;
   logic        m_pend;
   int          m_ps;
   bit          m_hist[$];
   bit          ext_lvl = 1'b0;
   logic [31:0] last_rd;
   logic        last_hit;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic bit in_win(input logic [31:0] a);
      return (a >= BASE) && ((a - BASE) < 32);
   endfunction

   function automatic bit is_word(input logic [31:0] a, input logic [2:0] mode);
      return (mode == 3'b010) && ((a % 4) == 0);
   endfunction

   function automatic logic [31:0] m_read(input logic [31:0] a, input logic [2:0] mode);
      int idx;
      if (!in_win(a) || !is_word(a, mode)) return 32'd0;
      idx = int'((a - BASE) / 4);
      case (idx)
         0: return m_mtime[31:0];
         1: return m_mtime[63:32];
         2: return m_cmp[31:0];
         3: return m_cmp[63:32];
         4: return {30'd0, m_ctrl};
         5: return {30'd0, m_pend, m_mtime >= m_cmp};
         default: return 32'd0;
      endcase
   endfunction

   task automatic model_reset();
      m_mtime = '0;
      m_cmp   = '1;
      m_ctrl  = '0;
      m_irq   = '0;
      m_pend  = 1'b0;
      m_ps    = 0;
      m_hist  = '{1'b0, 1'b0, 1'b0};
   endtask

   // One bus cycle: drive, check combinational outputs, clock, advance model, check interrupt.
   task automatic step(input bit rd, input bit wr, input logic [31:0] a,
                       input logic [31:0] wd, input logic [2:0] mode, input bit epc);
      logic [1:0]  irq_new;
      logic [63:0] nm;
      bit          edge_seen, clr, wr_ok;
      int          idx;
      rd_en = rd; wr_en = wr; addr = a; wdata = wd; mem_mode = mode;
      ext_irq = ext_lvl; epc_taken = epc;
      #1;
      last_hit = hit;
      last_rd  = rdata;
      check("hit", hit, in_win(a));
      check("rdata", rdata, rd ? m_read(a, mode) : 32'd0);
      @(posedge clk);
      irq_new   = {m_pend & m_ctrl[1], (m_mtime >= m_cmp) & m_ctrl[0]};
      edge_seen = m_hist[1] && !m_hist[2];
      wr_ok     = wr && in_win(a) && is_word(a, mode);
      idx       = int'((a - BASE) / 4);
      clr       = (epc && m_irq[1]) || (wr_ok && idx == 5 && wd[1]);
      m_ps++;
      nm = m_mtime;
      if (m_ps == PS) begin
         m_ps = 0;
         nm   = m_mtime + 64'd1;
      end
      if (wr_ok) begin
         case (idx)
            0: nm = {m_mtime[63:32], wd};
            1: nm = {wd, m_mtime[31:0]};
            2: m_cmp = {m_cmp[63:32], wd};
            3: m_cmp = {wd, m_cmp[31:0]};
            4: m_ctrl = wd[1:0];
            default: ;
         endcase
      end
      m_mtime = nm;
      if (edge_seen) m_pend = 1'b1;
      else if (clr)  m_pend = 1'b0;
      m_hist.push_front(ext_lvl);
      void'(m_hist.pop_back());
      m_irq = irq_new;
      #1;
      check("interrupt", interrupt, m_irq);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'd0, 32'd0, 3'b010, 1'b0);
   endtask

   task automatic wr_reg(input int off, input logic [31:0] v);
      step(1'b0, 1'b1, BASE + 32'(off), v, 3'b010, 1'b0);
   endtask

   task automatic rd_reg(input int off);
      step(1'b1, 1'b0, BASE + 32'(off), 32'd0, 3'b010, 1'b0);
   endtask

   initial begin
      int guard;
      model_reset();
      repeat (2) @(negedge clk);
      check("reset_irq", interrupt, 2'b00);
      rst = 1'b0;

      // Timer interrupt up, then asynchronous reset mid-count at mtime = 5
      wr_reg(12, 32'd0);
      wr_reg(8, 32'd0);
      wr_reg(16, 32'd1);
      guard = 0;
      while (m_mtime < 5 && guard < 20) begin idle(1); guard++; end
      check("pre_reset_irq", interrupt, 2'b01);
      #2 rst = 1'b1;
      #1 check("rst_async_irq", interrupt, 2'b00);
      rd_en = 1'b1; mem_mode = 3'b010; addr = BASE;
      #1 check("rst_mtime_lo", rdata, 32'd0);
      addr = BASE + 32'd8;
      #1 check("rst_cmp_lo", rdata, 32'hFFFF_FFFF);
      addr = BASE + 32'd12;
      #1 check("rst_cmp_hi", rdata, 32'hFFFF_FFFF);
      @(posedge clk);
      #1 check("rst_hold_irq", interrupt, 2'b00);
      @(negedge clk);
      rst = 1'b0;
      model_reset();

      // Timer compare rise and fall
      wr_reg(12, 32'd0);
      wr_reg(8, 32'd10);
      wr_reg(16, 32'd1);
      guard = 0;
      while (m_mtime != 64'd10 && guard < 50) begin idle(1); guard++; end
      check("t2_at10_irq0", interrupt[0], 1'b0);
      idle(1);
      check("t2_rise_irq0", interrupt[0], 1'b1);
      wr_reg(8, 32'd100);
      check("t2_wr_cycle_irq0", interrupt[0], 1'b1);
      idle(1);
      check("t2_fall_irq0", interrupt[0], 1'b0);

      // mtime carry and same-cycle write
      wr_reg(0, 32'hFFFF_FFFF);
      wr_reg(4, 32'd0);
      idle(1);
      rd_reg(0);
      check("t3_carry_lo", last_rd, 32'd0);
      rd_reg(4);
      check("t3_carry_hi", last_rd, 32'd1);
      wr_reg(0, 32'h0000_1234);
      rd_reg(4);
      check("t3_wr_hi_kept", last_rd, 32'd1);
      rd_reg(0);
      check("t3_wr_lo", last_rd, 32'h0000_1235);

      // External interrupt, held high: one edge only
      wr_reg(16, 32'd2);
      ext_lvl = 1'b1;
      idle(3);
      rd_reg(20);
      check("t4_status_pend", last_rd[1], 1'b1);
      check("t4_irq1_up", interrupt[1], 1'b1);
      step(1'b0, 1'b0, 32'd0, 32'd0, 3'b010, 1'b1);
      idle(1);
      check("t4_irq1_drop", interrupt[1], 1'b0);
      idle(4);
      check("t4_level_no_reset", interrupt[1], 1'b0);
      ext_lvl = 1'b0;
      idle(3);

      // Edge and epc_taken in the same cycle: set wins
      ext_lvl = 1'b1;
      idle(3);
      ext_lvl = 1'b0;
      idle(3);
      check("t5_irq1_up", interrupt[1], 1'b1);
      ext_lvl = 1'b1;
      idle(2);
      step(1'b0, 1'b0, 32'd0, 32'd0, 3'b010, 1'b1);
      idle(1);
      check("t5_set_wins", interrupt[1], 1'b1);
      step(1'b0, 1'b0, 32'd0, 32'd0, 3'b010, 1'b1);
      idle(1);
      check("t5_second_clear", interrupt[1], 1'b0);
      ext_lvl = 1'b0;
      idle(3);

      // Bus corner cases
      step(1'b0, 1'b1, BASE + 32'd16, 32'd3, 3'b000, 1'b0);
      step(1'b0, 1'b1, BASE + 32'd17, 32'd3, 3'b010, 1'b0);
      rd_reg(16);
      check("t6_byte_store_ignored", last_rd, 32'd2);
      rd_reg(24);
      check("t6_off18_zero", last_rd, 32'd0);
      step(1'b1, 1'b0, BASE + 32'd32, 32'd0, 3'b010, 1'b0);
      check("t6_outside_hit", last_hit, 1'b0);
      check("t6_outside_rdata", last_rd, 32'd0);
      step(1'b1, 1'b0, BASE + 32'd4, 32'd0, 3'b001, 1'b0);
      check("t6_half_load_zero", last_rd, 32'd0);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         logic [31:0] a, wd;
         logic [2:0]  md;
         bit          rd, wr, epc;
         if ($urandom_range(0, 99) < 85) begin
            a = BASE + 32'(4 * $urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) a = a + 32'($urandom_range(1, 3));
         end else begin
            a = $urandom;
         end
         md  = ($urandom_range(0, 99) < 85) ? 3'b010 : 3'($urandom_range(0, 7));
         wd  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 60)) : $urandom;
         rd  = ($urandom_range(0, 1) == 1);
         wr  = ($urandom_range(0, 9) < 3);
         epc = ($urandom_range(0, 99) < 15);
         if ($urandom_range(0, 4) == 0) ext_lvl = ~ext_lvl;
         step(rd, wr, a, wd, md, epc);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/intr_timer_ctrl.md
Name: intr_timer_ctrl

Overview:
- Memory-mapped machine timer and interrupt source on the core's data-memory bus.
- Answers the core's load/store requests: rd_en, wr_en, addr, wdata, mem_mode.
- Drives the two-bit interrupt vector into the CSR register file: bit0 is the machine timer interrupt, bit1 is the external interrupt.
- Takes the core's trap-acknowledge (epc_taken) to retire a serviced external interrupt.

Parameters:
- BASE_ADDR, 32'h0000_2000, byte base of the 32-byte register window.
- PRESCALE, 1, clk cycles per mtime increment (>=1).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- rd_en  in  1  load request from the core (same meaning as at data_mem).
- wr_en  in  1  store request from the core.
- addr  in  32  byte address (ALU result).
- wdata  in  32  store data.
- mem_mode  in  3  access size/sign code; 3'b010 is a word access.
- rdata  out  32  load data, combinational.
- hit  out  1  addr falls inside the window; the top level uses it to select rdata over data_mem output.
- ext_irq  in  1  asynchronous external interrupt line, active-high.
- epc_taken  in  1  one-cycle pulse when the core enters the trap handler.
- interrupt  out  2  [0] timer, [1] external; to CSR interrupt input.

Behaviour:
Address decode
- hit = (addr[31:5] == BASE_ADDR[31:5]).
- Register offset is addr[4:2].
- Only word accesses (mem_mode == 3'b010) with addr[1:0] == 0 act on a register.
- Any other store inside the window is ignored.
- Any other load inside the window returns 0.

Register map
- 0x00 MTIME_LO: rw.
- 0x04 MTIME_HI: rw.
- 0x08 MTIMECMP_LO: rw.
- 0x0C MTIMECMP_HI: rw.
- 0x10 CTRL: bit0 timer_en, bit1 ext_en, rw; other bits read 0.
- 0x14 STATUS: bit0 timer_pend (ro), bit1 ext_pend (write-1-to-clear).
- 0x18 and 0x1C: read 0, writes ignored.

Reads and writes
- rdata is combinational from addr; the core latches it in the same cycle, matching data_mem load timing.
- rdata = 0 when !hit or !rd_en.
- Writes take effect on the rising clk edge where wr_en && hit.

Reset values
- mtime = 0.
- mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF.
- CTRL = 0, ext_pend = 0, prescale counter = 0.
- Synchronizer flops = 0.
- interrupt = 2'b00, rdata = 0.

Timer
- Prescale counter counts 0..PRESCALE-1; mtime increments by 1 when it wraps.
- mtime is 64-bit and wraps from all-ones to 0 with no flag.
- A write to MTIME_LO/HI in the same cycle as an increment: the written half takes wdata; the other half keeps its pre-increment value (no carry applied that cycle).
- timer_pend = (mtime >= mtimecmp), unsigned 64-bit compare, evaluated combinationally on the current registers.

External interrupt
- ext_irq passes through a 2-flop synchronizer, then a rising-edge detector (sync2 & !sync3).
- A detected edge sets ext_pend.
- ext_pend clears on epc_taken while interrupt[1] is asserted, or on a STATUS write with wdata[1] = 1.
- A set (edge) in the same cycle as a clear: set wins, so pend stays 1.

Outputs
- interrupt is registered: interrupt[0] <= timer_pend & timer_en; interrupt[1] <= ext_pend & ext_en.
- Latency: one cycle from the cause register to the output.
- epc_taken while only interrupt[0] is high has no effect. The timer interrupt stays asserted until software raises MTIMECMP or clears timer_en.
- Assertion of rst mid-operation clears all state immediately, including any pending event, and the outputs go to 0 asynchronously.

Test Plan:
1. Reset: assert rst mid-count with mtime = 5 -> mtime = 0, MTIMECMP reads 32'hFFFF_FFFF from both halves, interrupt = 2'b00 during and after reset.
2. Timer: PRESCALE = 1; write MTIMECMP_HI = 0, MTIMECMP_LO = 10, CTRL = 1 -> interrupt[0] rises exactly one cycle after mtime reaches 10. Then write MTIMECMP_LO = 100 -> interrupt[0] falls one cycle after the write.
3. Wrap/carry: write MTIME_LO = 32'hFFFF_FFFF, MTIME_HI = 0 -> next increment reads HI = 1, LO = 0. Write MTIME_LO on an increment cycle -> LO = written value, HI unchanged.
4. External: CTRL = 2; pulse ext_irq high for 3 cycles -> STATUS[1] = 1 two to three cycles later, interrupt[1] one cycle after that. Pulse epc_taken -> interrupt[1] drops next cycle. Holding ext_irq high does not re-set pend (edge-triggered).
5. Simultaneous set/clear: new ext_irq edge detected in the same cycle as epc_taken -> ext_pend stays 1, interrupt[1] stays 1. A second epc_taken then clears it.
6. Bus corner cases: byte store (mem_mode = 3'b000) to CTRL -> CTRL unchanged; load at offset 0x18 -> 0; load outside the window -> hit = 0, rdata = 0.
